uc: RTL and testbench
=====================

UC -- requirements
Module: uc

Interface
REQ-001 The block SHALL have parameter STACK_W, default 16, meaning the width of stack, memory and data_pilha words.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the width of ROM/RAM addresses and of the instruction operand.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clock  in  1  system clock; all state changes on the rising edge.
REQ-005 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port inst  in  10  instruction from ROM: [9:5] opcode, [4:0] operand (address or immediate).
REQ-007 The block SHALL have port data_mem  in  16  RAM read data.
REQ-008 The block SHALL have port controle_ula  in  1  ALU compare flag: 1 = condition true.
REQ-009 The block SHALL have port pilha_wren  out  1  stack direction: 1 = push, 0 = pop (acts on a clock_pilha strobe).
REQ-010 The block SHALL have port ram_wren  out  1  RAM write enable.
REQ-011 The block SHALL have port controle_pilha  out  1  stack input select: 0 = data_pilha, 1 = ALU result.
REQ-012 The block SHALL have ports clock_pilha, clock_rom, clock_ram, clock_temp1, clock_temp2  out  1 each  one-cycle registered strobes for stack, ROM, RAM, temp1 and temp2.
REQ-013 The block SHALL have port a_rom  out  5  program counter.
REQ-014 The block SHALL have port data_pilha  out  16  value to push.
REQ-015 The block SHALL have port a_ram  out  5  RAM address.
REQ-016 The block SHALL have ports load_temp1, load_temp2  out  1 each  ALU operand register loads.
REQ-017 The block SHALL have port opcode  out  5  latched opcode to the ALU.

Function
REQ-018 The FSM register SHALL be named estado_atual (4 bits); states: 0 INIT, 1 FETCH, 2 DECODE, 3 MEM_READ, 4 PUSH, 5 MEM_WRITE, 6 POP_A, 7 POP_B, 8 ALU_WAIT, 9 PUSH_ALU, 10 BRANCH, 11 PC_INC.
REQ-019 The FSM SHALL take INIT -> FETCH unconditionally.
REQ-020 FETCH SHALL pulse clock_rom with a_rom = PC, then go to DECODE.
REQ-021 DECODE SHALL latch inst into the instruction register and drive opcode = IR[9:5].
REQ-022 Opcode 0, PUSH addr: MEM_READ (a_ram = operand, clock_ram pulse, ram_wren 0), then PUSH with data_pilha = data_mem, controle_pilha 0.
REQ-023 Opcode 1, PUSH_I imm: PUSH with data_pilha = zero-extended operand.
REQ-024 Opcode 2, POP addr: MEM_WRITE with pilha_wren 0 and clock_pilha pulse, then a_ram = operand, ram_wren 1 and clock_ram pulse.
REQ-025 Opcode 3, POP: a single pop strobe (pilha_wren 0, clock_pilha), then PC_INC.
REQ-026 Opcodes 4–12, ALU ops: POP_A (pop, load_temp1 and clock_temp1), POP_B (pop, load_temp2 and clock_temp2), ALU_WAIT, then PUSH_ALU (controle_pilha 1, pilha_wren 1, clock_pilha).
REQ-027 Opcode 13, GOTO addr: BRANCH sets PC = operand and returns to FETCH, without PC_INC.
REQ-028 Opcode 14, IF_TRUE addr: PC = operand if controle_ula = 1 in BRANCH; otherwise go to PC_INC.
REQ-029 Opcode 15, IF_FALSE addr: PC = operand if controle_ula = 0 in BRANCH; otherwise go to PC_INC.
REQ-030 Opcodes 16–31 SHALL be NOPs: DECODE -> PC_INC.
REQ-031 PUSH, MEM_WRITE and PUSH_ALU SHALL go to PC_INC, where PC = PC+1 mod 32, then go to FETCH.
REQ-032 Every strobe and enable SHALL be high only in its state, registered, for exactly one cycle.
REQ-033 Every non-strobe output SHALL hold its value outside its state.
REQ-034 The longest instruction SHALL take at most 8 cycles from FETCH to the next FETCH.
REQ-035 Changes on inst outside DECODE SHALL be ignored.

Reset
REQ-036 While reset = 1, the block SHALL hold: estado_atual = INIT, PC = 0, IR = 0, opcode = 0, all strobes/enables = 0, controle_pilha = 0, data_pilha = 0, a_ram = 0.
REQ-037 Reset asserted mid-instruction SHALL abort the instruction with no further strobes.
REQ-038 The first FETCH SHALL occur 2 rising edges after reset is released.

Structure
REQ-039 A shared package uc_pkg SHALL hold the state encodings, the opcode constants (PUSH=0, PUSH_I=1, POP_M=2, POP=3, ALU_FIRST=4, ALU_LAST=12, GOTO=13, IF_TRUE=14, IF_FALSE=15) and the widths.
REQ-040 The block SHALL be a single module with no sub-modules; the PC register stays inline.

Verification
REQ-041 Reset, then inst = {0, 5'd0} with data_mem = 16'h1234 -> one clock_ram pulse with a_ram 0, then one push with data_pilha 16'h1234, then PC 0 -> 1.
REQ-042 inst = {1, 5'd7} -> data_pilha = 16'h0007, pilha_wren = 1 and a single clock_pilha pulse; ram_wren stays 0.
REQ-043 inst = {4, x} -> sequence load_temp1, load_temp2, then push with controle_pilha = 1; opcode = 4 throughout.
REQ-044 inst = {13, 5'd9} -> a_rom = 9 at the next FETCH.
REQ-045 inst = {14, 5'd3} -> a_rom = 3 when controle_ula = 1; PC + 1 when controle_ula = 0.
REQ-046 inst = {15, 5'd3} -> a_rom = 3 when controle_ula = 0; PC + 1 when controle_ula = 1.
REQ-047 Reset asserted while in POP_A -> next state INIT and all strobes 0.
REQ-048 PC = 31 followed by PC_INC -> PC = 0.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared definitions for the uc stack-machine control unit:
// widths, FSM state encodings and opcode constants.
package uc_pkg;

   localparam int unsigned STACK_W_DEF = 16;
   localparam int unsigned ADDR_W_DEF  = 5;
   localparam int unsigned OPCODE_W    = 5;

   typedef enum logic [3:0] {
      INIT      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_READ  = 4'd3,
      PUSH      = 4'd4,
      MEM_WRITE = 4'd5,
      POP_A     = 4'd6,
      POP_B     = 4'd7,
      ALU_WAIT  = 4'd8,
      PUSH_ALU  = 4'd9,
      BRANCH    = 4'd10,
      PC_INC    = 4'd11
   } estado_t;

   localparam logic [OPCODE_W-1:0] OP_PUSH      = 5'd0;
   localparam logic [OPCODE_W-1:0] OP_PUSH_I    = 5'd1;
   localparam logic [OPCODE_W-1:0] OP_POP_M     = 5'd2;
   localparam logic [OPCODE_W-1:0] OP_POP       = 5'd3;
   localparam logic [OPCODE_W-1:0] OP_ALU_FIRST = 5'd4;
   localparam logic [OPCODE_W-1:0] OP_ALU_LAST  = 5'd12;
   localparam logic [OPCODE_W-1:0] OP_GOTO      = 5'd13;
   localparam logic [OPCODE_W-1:0] OP_IF_TRUE   = 5'd14;
   localparam logic [OPCODE_W-1:0] OP_IF_FALSE  = 5'd15;

   function automatic logic is_alu(input logic [OPCODE_W-1:0] op);
      return (op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST);
   endfunction

endpackage

// File: rtl/uc.sv
// Control unit of the stack machine: fetch/decode FSM driving ROM, RAM,
// stack and ALU operand registers through registered one-cycle strobes.
module uc
   import uc_pkg::*;
#(
   parameter int unsigned STACK_W = STACK_W_DEF,
   parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [OPCODE_W+ADDR_W-1:0] inst,
   input  logic [STACK_W-1:0]         data_mem,
   input  logic                       controle_ula,
   output logic                       pilha_wren,
   output logic                       ram_wren,
   output logic                       controle_pilha,
   output logic                       clock_pilha,
   output logic                       clock_rom,
   output logic                       clock_ram,
   output logic                       clock_temp1,
   output logic                       clock_temp2,
   output logic [ADDR_W-1:0]          a_rom,
   output logic [STACK_W-1:0]         data_pilha,
   output logic [ADDR_W-1:0]          a_ram,
   output logic                       load_temp1,
   output logic                       load_temp2,
   output logic [OPCODE_W-1:0]        opcode
);

   estado_t                     estado_atual, estado_prox;
   logic [ADDR_W-1:0]           pc, pc_d;
   logic [OPCODE_W+ADDR_W-1:0]  ir, ir_d;
   logic [OPCODE_W-1:0]         inst_op, ir_op, opcode_d;
   logic [ADDR_W-1:0]           ir_operand, a_ram_d;
   logic [STACK_W-1:0]          data_pilha_d;
   logic                        desvio;
   logic pilha_wren_d, ram_wren_d, controle_pilha_d, clock_pilha_d, clock_rom_d;
   logic clock_ram_d, clock_temp1_d, clock_temp2_d, load_temp1_d, load_temp2_d;

   assign inst_op    = inst[OPCODE_W+ADDR_W-1 -: OPCODE_W];
   assign ir_op      = ir[OPCODE_W+ADDR_W-1 -: OPCODE_W];
   assign ir_operand = ir[ADDR_W-1:0];
   assign a_rom      = pc;

   assign desvio = (ir_op == OP_GOTO)
                 | ((ir_op == OP_IF_TRUE)  &  controle_ula)
                 | ((ir_op == OP_IF_FALSE) & ~controle_ula);

   always_ff @(posedge clock) begin
      if (reset) estado_atual <= INIT;
      else       estado_atual <= estado_prox;
   end

   // DECODE steers on the raw inst, since IR is only loaded at the end of it.
   always_comb begin
      estado_prox = INIT;
      case (estado_atual)
         INIT:      estado_prox = FETCH;
         FETCH:     estado_prox = DECODE;
         DECODE: begin
            case (inst_op)
               OP_PUSH:     estado_prox = MEM_READ;
               OP_PUSH_I:   estado_prox = PUSH;
               OP_POP_M:    estado_prox = MEM_WRITE;
               OP_POP:      estado_prox = PC_INC;
               OP_GOTO,
               OP_IF_TRUE,
               OP_IF_FALSE: estado_prox = BRANCH;
               default:     estado_prox = is_alu(inst_op) ? POP_A : PC_INC;
            endcase
         end
         MEM_READ:  estado_prox = PUSH;
         PUSH:      estado_prox = PC_INC;
         MEM_WRITE: estado_prox = PC_INC;
         POP_A:     estado_prox = POP_B;
         POP_B:     estado_prox = ALU_WAIT;
         ALU_WAIT:  estado_prox = PUSH_ALU;
         PUSH_ALU:  estado_prox = PC_INC;
         BRANCH:    estado_prox = desvio ? FETCH : PC_INC;
         PC_INC:    estado_prox = FETCH;
         default:   estado_prox = INIT;
      endcase
   end

   always_comb begin
      pc_d             = pc;
      ir_d             = ir;
      opcode_d         = opcode;
      a_ram_d          = a_ram;
      data_pilha_d     = data_pilha;
      pilha_wren_d     = pilha_wren;
      controle_pilha_d = controle_pilha;
      ram_wren_d       = 1'b0;
      clock_pilha_d    = 1'b0;
      clock_rom_d      = 1'b0;
      clock_ram_d      = 1'b0;
      clock_temp1_d    = 1'b0;
      clock_temp2_d    = 1'b0;
      load_temp1_d     = 1'b0;
      load_temp2_d     = 1'b0;
      case (estado_atual)
         FETCH: clock_rom_d = 1'b1;
         DECODE: begin
            ir_d     = inst;
            opcode_d = inst_op;
            // Both pop flavours issue their stack pop straight from decode.
            if (inst_op == OP_POP_M || inst_op == OP_POP) begin
               pilha_wren_d  = 1'b0;
               clock_pilha_d = 1'b1;
            end
         end
         MEM_READ: begin
            a_ram_d     = ir_operand;
            ram_wren_d  = 1'b0;
            clock_ram_d = 1'b1;
         end
         PUSH: begin
            data_pilha_d     = (ir_op == OP_PUSH) ? data_mem : STACK_W'(ir_operand);
            controle_pilha_d = 1'b0;
            pilha_wren_d     = 1'b1;
            clock_pilha_d    = 1'b1;
         end
         MEM_WRITE: begin
            a_ram_d     = ir_operand;
            ram_wren_d  = 1'b1;
            clock_ram_d = 1'b1;
         end
         POP_A: begin
            pilha_wren_d  = 1'b0;
            clock_pilha_d = 1'b1;
            load_temp1_d  = 1'b1;
            clock_temp1_d = 1'b1;
         end
         POP_B: begin
            pilha_wren_d  = 1'b0;
            clock_pilha_d = 1'b1;
            load_temp2_d  = 1'b1;
            clock_temp2_d = 1'b1;
         end
         PUSH_ALU: begin
            controle_pilha_d = 1'b1;
            pilha_wren_d     = 1'b1;
            clock_pilha_d    = 1'b1;
         end
         BRANCH: if (desvio) pc_d = ir_operand;
         PC_INC: pc_d = pc + ADDR_W'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc             <= '0;
         ir             <= '0;
         opcode         <= '0;
         a_ram          <= '0;
         data_pilha     <= '0;
         pilha_wren     <= 1'b0;
         controle_pilha <= 1'b0;
         ram_wren       <= 1'b0;
         clock_pilha    <= 1'b0;
         clock_rom      <= 1'b0;
         clock_ram      <= 1'b0;
         clock_temp1    <= 1'b0;
         clock_temp2    <= 1'b0;
         load_temp1     <= 1'b0;
         load_temp2     <= 1'b0;
      end else begin
         pc             <= pc_d;
         ir             <= ir_d;
         opcode         <= opcode_d;
         a_ram          <= a_ram_d;
         data_pilha     <= data_pilha_d;
         pilha_wren     <= pilha_wren_d;
         controle_pilha <= controle_pilha_d;
         ram_wren       <= ram_wren_d;
         clock_pilha    <= clock_pilha_d;
         clock_rom      <= clock_rom_d;
         clock_ram      <= clock_ram_d;
         clock_temp1    <= clock_temp1_d;
         clock_temp2    <= clock_temp2_d;
         load_temp1     <= load_temp1_d;
         load_temp2     <= load_temp2_d;
      end
   end

endmodule

// File: tb/tb_uc.sv
// Directed bench for uc: per-cycle strobe patterns and held outputs for each
// instruction class, branch outcomes, PC wrap and mid-instruction reset.
module tb_uc;

   logic        clock = 1'b0;
   logic        reset;
   logic [9:0]  inst;
   logic [15:0] data_mem;
   logic        controle_ula;
   logic        pilha_wren, ram_wren, controle_pilha, clock_pilha, clock_rom;
   logic        clock_ram, clock_temp1, clock_temp2, load_temp1, load_temp2;
   logic [4:0]  a_rom, a_ram, opcode;
   logic [15:0] data_pilha;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [7:0] Z   = 8'h00;
   localparam logic [7:0] ROM = 8'h80;
   localparam logic [7:0] RAM = 8'h40;
   localparam logic [7:0] RWE = 8'h20;
   localparam logic [7:0] PIL = 8'h10;
   localparam logic [7:0] LT1 = 8'h08;
   localparam logic [7:0] CT1 = 8'h04;
   localparam logic [7:0] LT2 = 8'h02;
   localparam logic [7:0] CT2 = 8'h01;
   localparam logic [9:0] GARBAGE = {5'd13, 5'd5};

   uc #(.STACK_W(16), .ADDR_W(5)) dut (
      .clock(clock), .reset(reset), .inst(inst), .data_mem(data_mem),
      .controle_ula(controle_ula), .pilha_wren(pilha_wren), .ram_wren(ram_wren),
      .controle_pilha(controle_pilha), .clock_pilha(clock_pilha),
      .clock_rom(clock_rom), .clock_ram(clock_ram), .clock_temp1(clock_temp1),
      .clock_temp2(clock_temp2), .a_rom(a_rom), .data_pilha(data_pilha),
      .a_ram(a_ram), .load_temp1(load_temp1), .load_temp2(load_temp2),
      .opcode(opcode)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] strobes();
      return {clock_rom, clock_ram, ram_wren, clock_pilha,
              load_temp1, clock_temp1, load_temp2, clock_temp2};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Entered with the ROM strobe of the instruction visible; returns on the next one.
   task automatic run_instr(input string name, input logic [9:0] i, input logic ula,
                            input int n, input logic [63:0] seq, input logic [4:0] exp_pc,
                            input logic [15:0] exp_dp, input logic [4:0] exp_aram,
                            input logic exp_pw, input logic exp_cp);
      inst = i;
      controle_ula = ula;
      for (int k = 1; k <= n; k++) begin
         step();
         if (k == 1) inst = GARBAGE;
         check($sformatf("%s strobes k%0d", name, k), strobes(), seq[63-8*(k-1) -: 8]);
         check($sformatf("%s opcode k%0d", name, k), opcode, i[9:5]);
      end
      check({name, " a_rom"}, a_rom, exp_pc);
      check({name, " data_pilha"}, data_pilha, exp_dp);
      check({name, " a_ram"}, a_ram, exp_aram);
      check({name, " pilha_wren"}, pilha_wren, exp_pw);
      check({name, " controle_pilha"}, controle_pilha, exp_cp);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " strobes"}, strobes(), 8'h00);
      check({tag, " estado"}, dut.estado_atual, 4'd0);
      check({tag, " a_rom"}, a_rom, 5'd0);
      check({tag, " opcode"}, opcode, 5'd0);
      check({tag, " data_pilha"}, data_pilha, 16'h0000);
      check({tag, " a_ram"}, a_ram, 5'd0);
      check({tag, " controle_pilha"}, controle_pilha, 1'b0);
      check({tag, " pilha_wren"}, pilha_wren, 1'b0);
   endtask

   task automatic release_reset(input string tag);
      reset = 1'b0;
      step();
      check({tag, " first edge rom"}, clock_rom, 1'b0);
      step();
      check({tag, " second edge rom"}, clock_rom, 1'b1);
      check({tag, " first fetch pc"}, a_rom, 5'd0);
   endtask

   initial begin
      reset = 1'b1;
      inst = '0;
      data_mem = 16'h1234;
      controle_ula = 1'b0;
      repeat (3) step();
      check_idle("reset");
      release_reset("boot");

      run_instr("push_mem", {5'd0, 5'd0}, 1'b0, 5, {Z, RAM, PIL, Z, ROM, Z, Z, Z},
                5'd1, 16'h1234, 5'd0, 1'b1, 1'b0);
      run_instr("push_imm", {5'd1, 5'd7}, 1'b0, 4, {Z, PIL, Z, ROM, Z, Z, Z, Z},
                5'd2, 16'h0007, 5'd0, 1'b1, 1'b0);
      run_instr("pop_mem", {5'd2, 5'd5}, 1'b0, 4, {PIL, RAM|RWE, Z, ROM, Z, Z, Z, Z},
                5'd3, 16'h0007, 5'd5, 1'b0, 1'b0);
      run_instr("alu", {5'd4, 5'd3}, 1'b0, 7,
                {Z, PIL|LT1|CT1, PIL|LT2|CT2, Z, PIL, Z, ROM, Z},
                5'd4, 16'h0007, 5'd5, 1'b1, 1'b1);
      run_instr("pop", {5'd3, 5'd0}, 1'b0, 3, {PIL, Z, ROM, Z, Z, Z, Z, Z},
                5'd5, 16'h0007, 5'd5, 1'b0, 1'b1);
      run_instr("goto", {5'd13, 5'd9}, 1'b0, 3, {Z, Z, ROM, Z, Z, Z, Z, Z},
                5'd9, 16'h0007, 5'd5, 1'b0, 1'b1);
      run_instr("if_true taken", {5'd14, 5'd3}, 1'b1, 3, {Z, Z, ROM, Z, Z, Z, Z, Z},
                5'd3, 16'h0007, 5'd5, 1'b0, 1'b1);
      run_instr("if_true not", {5'd14, 5'd3}, 1'b0, 4, {Z, Z, Z, ROM, Z, Z, Z, Z},
                5'd4, 16'h0007, 5'd5, 1'b0, 1'b1);
      run_instr("if_false taken", {5'd15, 5'd3}, 1'b0, 3, {Z, Z, ROM, Z, Z, Z, Z, Z},
                5'd3, 16'h0007, 5'd5, 1'b0, 1'b1);
      run_instr("if_false not", {5'd15, 5'd3}, 1'b1, 4, {Z, Z, Z, ROM, Z, Z, Z, Z},
                5'd4, 16'h0007, 5'd5, 1'b0, 1'b1);
      run_instr("nop", {5'd20, 5'd17}, 1'b0, 3, {Z, Z, ROM, Z, Z, Z, Z, Z},
                5'd5, 16'h0007, 5'd5, 1'b0, 1'b1);
      run_instr("goto 31", {5'd13, 5'd31}, 1'b0, 3, {Z, Z, ROM, Z, Z, Z, Z, Z},
                5'd31, 16'h0007, 5'd5, 1'b0, 1'b1);
      run_instr("pc wrap", {5'd1, 5'd31}, 1'b0, 4, {Z, PIL, Z, ROM, Z, Z, Z, Z},
                5'd0, 16'h001F, 5'd5, 1'b1, 1'b0);

      // Abort an ALU instruction while the FSM sits in POP_A.
      inst = {5'd5, 5'd0};
      step();
      check("abort in pop_a estado", dut.estado_atual, 4'd6);
      reset = 1'b1;
      step();
      check_idle("abort");
      step();
      check("abort hold strobes", strobes(), 8'h00);
      release_reset("reboot");
      run_instr("after reboot", {5'd1, 5'd2}, 1'b0, 4, {Z, PIL, Z, ROM, Z, Z, Z, Z},
                5'd1, 16'h0002, 5'd0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
